mult_div_unit: RTL and testbench

Iterative signed multiply/divide unit holding the HI/LO register pair for the multicycle MIPS datapath. It sits directly downstream of the control unit: control pulses `start` with an operation select, waits on `busy`/`done`, and reads `hi`/`lo` for MFHI/MFLO. It reports divide-by-zero back to control on `div0`. MULT produces a 64-bit product; DIV produces a quotient in LO and a remainder in HI.

---
 rtl/md_pkg.sv | 22 ++
 rtl/md_iter_step.sv | 35 +++
 rtl/mult_div_unit.sv | 116 +++++++++++
 tb/tb_mult_div_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // Widened by one bit so the magnitude of the most negative value is exact.
    function automatic logic [MD_WIDTH:0] md_abs(input logic [MD_WIDTH-1:0] x);
        logic [MD_WIDTH:0] ext;
        ext = {x[MD_WIDTH-1], x};
        return x[MD_WIDTH-1] ? -ext : ext;
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on magnitudes.
module md_iter_step
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             op_i,
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH:0]   opnd_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        sum     = {1'b0, rem_i} + (acc_i[0] ? opnd_i : '0);
        shifted = {rem_i, acc_i[WIDTH-1]};
        // Partial remainder stays below 2^WIDTH, so the MSB of diff is the borrow.
        diff    = shifted - opnd_i;
        ge      = ~diff[WIDTH];
        if (op_i == MD_MULT) begin
            rem_o = sum[WIDTH:1];
            acc_o = {sum[0], acc_i[WIDTH-1:1]};
        end else begin
            rem_o = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            acc_o = {acc_i[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV with HI/LO registers; 33-cycle latency, div-by-zero abort.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e        state_q;
    logic             op_q, sa_q, sb_q, done_q, div0_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   opnd_q;
    logic [WIDTH-1:0] rem_q, rem_d, acc_q, acc_d, hi_q, lo_q;

    logic [WIDTH:0]     abs_a, abs_b, init_lo;
    logic               unused_msb;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    assign abs_a      = md_abs(a);
    assign abs_b      = md_abs(b);
    assign init_lo    = (op == MD_DIV) ? abs_a : abs_b;
    assign unused_msb = init_lo[WIDTH];

    always_comb begin
        prod_res = (sa_q ^ sb_q) ? -{rem_q, acc_q} : {rem_q, acc_q};
        quo_res  = (sa_q ^ sb_q) ? -acc_q : acc_q;
        rem_res  = sa_q ? -rem_q : rem_q;
    end

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .op_i   (op_q),
        .rem_i  (rem_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .rem_o  (rem_d),
        .acc_o  (acc_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= MD_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            cnt_q   <= '0;
            opnd_q  <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == MD_DIV && b == '0) begin
                            done_q <= 1'b1;
                            div0_q <= 1'b1;
                        end else begin
                            op_q    <= op;
                            sa_q    <= a[WIDTH-1];
                            sb_q    <= b[WIDTH-1];
                            opnd_q  <= (op == MD_DIV) ? abs_b : abs_a;
                            acc_q   <= init_lo[WIDTH-1:0];
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    if (op_q == MD_MULT) begin
                        hi_q <= prod_res[2*WIDTH-1:WIDTH];
                        lo_q <= prod_res[WIDTH-1:0];
                    end else begin
                        hi_q <= rem_res;
                        lo_q <= quo_res;
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;
    int lat   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request so that the next rising edge (E0) samples it.
    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic wait_done(output int l);
        int guard;
        guard = 0;
        while (!done && guard < 100) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        l = cyc - e0;
    endtask

    initial begin
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_div0", {63'd0, div0}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // MULT 7 * -3
        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        check("mul1_busy", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check("mul1_lat", 64'(lat), 64'd33);
        check("mul1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul1_div0", {63'd0, div0}, 64'd0);
        check("mul1_busy_done", {63'd0, busy}, 64'd0);
        @(posedge clock); #1;
        check("mul1_done_pulse", {63'd0, done}, 64'd0);

        // MULT -2^31 * -2^31
        launch(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat);
        check("mul2_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

        // DIV -7 / 2
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        check("div1_lat", 64'(lat), 64'd33);
        check("div1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIV -2^31 / -1
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check("div2_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        check("div2_div0", {63'd0, div0}, 64'd0);

        // Preload HI=LO=0x12345678: 805654952 * 1628201331 = 0x12345678_12345678
        launch(1'b0, 32'd805654952, 32'd1628201331);
        wait_done(lat);
        check("pre_hilo", {hi, lo}, 64'h1234_5678_1234_5678);

        // DIV 5 / 0: abort at E0
        launch(1'b1, 32'd5, 32'd0);
        check("dz_done", {63'd0, done}, 64'd1);
        check("dz_div0", {63'd0, div0}, 64'd1);
        check("dz_busy", {63'd0, busy}, 64'd0);
        check("dz_hilo", {hi, lo}, 64'h1234_5678_1234_5678);
        @(posedge clock); #1;
        check("dz_done_off", {61'd0, done, div0, busy}, 64'd0);

        // MULT 1000*1000 with a div-by-zero request at E10 that must be ignored
        @(negedge clock);
        launch(1'b0, 32'd1000, 32'd1000);
        repeat (9) @(posedge clock);
        #1;
        start = 1'b1; op = 1'b1; a = 32'd1; b = 32'd0;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("ign_state", {61'd0, busy, done, div0}, 64'b100);
        wait_done(lat);
        check("ign_lat", 64'(lat), 64'd33);
        check("ign_hilo", {hi, lo}, 64'd1000000);
        check("ign_div0", {63'd0, div0}, 64'd0);

        // Back-to-back: MULT 7*-3 then DIV 1000 / -9 launched in the done cycle
        @(negedge clock);
        launch(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat);
        check("b2b_first", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        launch(1'b1, 32'd1000, 32'hFFFF_FFF7);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_hilo", {hi, lo}, 64'h0000_0001_FFFF_FF91);

        // Reset asserted at E15 of a DIV
        @(negedge clock);
        launch(1'b1, 32'd12345, 32'd67);
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        launch(1'b1, 32'd100, 32'd7);
        wait_done(lat);
        check("post_lat", 64'(lat), 64'd33);
        check("post_hilo", {hi, lo}, {32'd2, 32'd14});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
